// File: rtl/result_writer_pkg.sv
// Shared widths and types for the result write path into the calculator SRAM.
// A result pair packs into one SRAM word, so MEM_WORD_SIZE is twice DATA_W.
package result_writer_pkg;

    localparam int DATA_W        = 32;
    localparam int MEM_WORD_SIZE = 64;
    localparam int ADDR_W        = 9;

    typedef enum logic [2:0] {IDLE, LOW, HIGH, WRITE, DONE} writer_state_t;

    typedef logic [ADDR_W-1:0]        addr_t;
    typedef logic [MEM_WORD_SIZE-1:0] mem_word_t;
    typedef logic [DATA_W-1:0]        data_t;

endpackage

// File: rtl/result_writer_if.sv
// Result stream into the writer plus the SRAM write port out of it.
// master = calculator/SRAM side, slave = result_writer.
interface result_writer_if;
    import result_writer_pkg::*;

    // Result beat transfers on a rising edge where result_valid_i && result_ready_o.
    // The producer holds data stable while valid is high and not yet accepted.
    logic      result_valid_i;
    logic      result_ready_o;
    data_t     result_data_i;

    logic      sram_write_o;
    addr_t     sram_addr_o;
    mem_word_t sram_wdata_o;

    modport master (
        output result_valid_i, result_data_i,
        input  result_ready_o, sram_write_o, sram_addr_o, sram_wdata_o
    );

    modport slave (
        input  result_valid_i, result_data_i,
        output result_ready_o, sram_write_o, sram_addr_o, sram_wdata_o
    );

endinterface

// File: rtl/result_writer.sv
// Packs pairs of results into SRAM words and writes them over a programmed
// address range (modulo 2^ADDR_W), finishing early on flush.
module result_writer
    import result_writer_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start_i,
    input  addr_t         write_start_addr_i,
    input  addr_t         write_end_addr_i,
    input  logic          flush_i,
    result_writer_if.slave bus,
    output logic          busy_o,
    output logic          done_o,
    output writer_state_t dbg_state_o
);

    writer_state_t state;
    addr_t         cur_addr;
    addr_t         end_addr;
    data_t         lo;
    logic          last;
    addr_t         sram_addr_q;
    mem_word_t     sram_wdata_q;

    // The SRAM address/data registers load only on the transition into WRITE,
    // so they hold their last written values at all other times.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cur_addr     <= '0;
            end_addr     <= '0;
            lo           <= '0;
            last         <= 1'b0;
            sram_addr_q  <= '0;
            sram_wdata_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        cur_addr <= write_start_addr_i;
                        end_addr <= write_end_addr_i;
                        state    <= LOW;
                    end
                end
                LOW: begin
                    if (bus.result_valid_i) begin
                        lo <= bus.result_data_i;
                        if (flush_i) begin
                            last         <= 1'b1;
                            sram_addr_q  <= cur_addr;
                            sram_wdata_q <= {data_t'(0), bus.result_data_i};
                            state        <= WRITE;
                        end else begin
                            state <= HIGH;
                        end
                    end else if (flush_i) begin
                        state <= DONE;
                    end
                end
                HIGH: begin
                    if (bus.result_valid_i) begin
                        last         <= flush_i;
                        sram_addr_q  <= cur_addr;
                        sram_wdata_q <= {bus.result_data_i, lo};
                        state        <= WRITE;
                    end else if (flush_i) begin
                        last         <= 1'b1;
                        sram_addr_q  <= cur_addr;
                        sram_wdata_q <= {data_t'(0), lo};
                        state        <= WRITE;
                    end
                end
                WRITE: begin
                    if (last || (cur_addr == end_addr)) begin
                        state <= DONE;
                    end else begin
                        cur_addr <= addr_t'(cur_addr + 1'b1);
                        state    <= LOW;
                    end
                end
                DONE: begin
                    last  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.result_ready_o = (state == LOW) || (state == HIGH);
    assign bus.sram_write_o   = (state == WRITE);
    assign bus.sram_addr_o    = sram_addr_q;
    assign bus.sram_wdata_o   = sram_wdata_q;
    assign busy_o             = (state != IDLE);
    assign done_o             = (state == DONE);
    assign dbg_state_o        = state;

endmodule

// File: tb/tb_result_writer.sv
// Randomised bench for result_writer: transaction-level pairing model,
// per-cycle output compare, write scoreboard and literal scenario checks.
module tb_result_writer;
    import result_writer_pkg::*;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          start_i = 1'b0;
    logic          flush_i = 1'b0;
    addr_t         ws = '0;
    addr_t         we = '0;
    logic          busy_o;
    logic          done_o;
    writer_state_t dbg_state;

    result_writer_if bus();

    result_writer dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .start_i            (start_i),
        .write_start_addr_i (ws),
        .write_end_addr_i   (we),
        .flush_i            (flush_i),
        .bus                (bus),
        .busy_o             (busy_o),
        .done_o             (done_o),
        .dbg_state_o        (dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // behavioural model: phase 0 idle, 1 collecting, 2 writing, 3 done
    int        m_phase = 0;
    addr_t     m_cur = '0;
    addr_t     m_end = '0;
    addr_t     m_addr = '0;
    mem_word_t m_wdata = '0;
    bit        m_last = 1'b0;
    data_t     m_buf[$];
    logic [ADDR_W+MEM_WORD_SIZE-1:0] exp_q[$];
    addr_t     log_a[$];
    mem_word_t log_d[$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = 0;
            m_cur   = '0;
            m_end   = '0;
            m_addr  = '0;
            m_wdata = '0;
            m_last  = 1'b0;
            m_buf.delete();
            exp_q.delete();
        end else begin
            case (m_phase)
                0: if (start_i) begin
                    m_cur   = ws;
                    m_end   = we;
                    m_phase = 1;
                    m_buf.delete();
                end
                1: begin
                    if (bus.result_valid_i) m_buf.push_back(bus.result_data_i);
                    if (m_buf.size() == 2 || (flush_i && m_buf.size() == 1)) begin
                        m_addr  = m_cur;
                        m_wdata = (m_buf.size() == 2) ? {m_buf[1], m_buf[0]} : {data_t'(0), m_buf[0]};
                        m_last  = flush_i;
                        m_buf.delete();
                        m_phase = 2;
                        exp_q.push_back({m_addr, m_wdata});
                    end else if (flush_i) begin
                        m_phase = 3;
                    end
                end
                2: if (m_last || m_cur == m_end) m_phase = 3;
                   else begin
                       m_cur   = addr_t'(m_cur + 1);
                       m_phase = 1;
                   end
                default: m_phase = 0;
            endcase
        end
    end

    // per-cycle compare and write scoreboard
    always @(negedge clk) begin
        check("ctrl ready/write/busy/done",
              {bus.result_ready_o, bus.sram_write_o, busy_o, done_o},
              {m_phase == 1, m_phase == 2, m_phase != 0, m_phase == 3});
        check("sram_addr", bus.sram_addr_o, m_addr);
        check("sram_wdata", bus.sram_wdata_o, m_wdata);
        if (bus.sram_write_o) begin
            log_a.push_back(bus.sram_addr_o);
            log_d.push_back(bus.sram_wdata_o);
            check("sb_queue_nonempty", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0)
                check("sb_write", {bus.sram_addr_o, bus.sram_wdata_o}, exp_q.pop_front());
        end
    end

    // driver tasks (called at a falling edge)
    task automatic do_start(input addr_t s, input addr_t e);
        start_i = 1'b1;
        ws = s;
        we = e;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    task automatic send(input data_t d, input int gap);
        int cnt;
        repeat (gap) @(negedge clk);
        bus.result_valid_i = 1'b1;
        bus.result_data_i  = d;
        cnt = 0;
        while (!bus.result_ready_o && cnt < 64) begin
            @(negedge clk);
            cnt++;
        end
        check("send_wait_bounded", cnt < 64, 1'b1);
        @(negedge clk);
        bus.result_valid_i = 1'b0;
    endtask

    task automatic do_flush(input bit with_data, input data_t d);
        int cnt;
        cnt = 0;
        while (!bus.result_ready_o && cnt < 64) begin
            @(negedge clk);
            cnt++;
        end
        check("flush_wait_bounded", cnt < 64, 1'b1);
        flush_i = 1'b1;
        if (with_data) begin
            bus.result_valid_i = 1'b1;
            bus.result_data_i  = d;
        end
        @(negedge clk);
        flush_i = 1'b0;
        bus.result_valid_i = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        int cnt;
        cnt = 0;
        while (!done_o && cnt < limit) begin
            @(negedge clk);
            cnt++;
        end
        check("done_seen", cnt < limit, 1'b1);
        @(negedge clk);
    endtask

    task automatic clear_log();
        log_a.delete();
        log_d.delete();
    endtask

    task automatic check_entry(input string name, input int idx, input addr_t a, input mem_word_t d);
        check({name, "_addr"}, log_a.size() > idx ? log_a[idx] : addr_t'('1), a);
        check({name, "_data"}, log_d.size() > idx ? log_d[idx] : mem_word_t'('1), d);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        data_t a, b, c;
        int    w, k;
        bit    use_flush;
        addr_t s;

        bus.result_valid_i = 1'b0;
        bus.result_data_i  = '0;
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_outputs",
              {bus.result_ready_o, bus.sram_write_o, busy_o, done_o, bus.sram_addr_o, bus.sram_wdata_o},
              '0);
        check("reset_dbg_state", dbg_state, IDLE);
        rst_n = 1'b1;
        @(negedge clk);

        // basic pair
        clear_log();
        do_start(9'h000, 9'h000);
        send(32'h11111111, 0);
        send(32'h22222222, 0);
        wait_done(20);
        check("basic_count", log_a.size(), 1);
        check_entry("basic", 0, 9'h000, 64'h2222222211111111);

        // multi-word back-to-back
        clear_log();
        do_start(9'h010, 9'h012);
        for (int i = 1; i <= 6; i++) send(data_t'(i), 0);
        wait_done(20);
        check("multi_count", log_a.size(), 3);
        check_entry("multi0", 0, 9'h010, 64'h0000000200000001);
        check_entry("multi1", 1, 9'h011, 64'h0000000400000003);
        check_entry("multi2", 2, 9'h012, 64'h0000000600000005);

        // wrap 0x1FF -> 0x001
        clear_log();
        do_start(9'h1FF, 9'h001);
        for (int i = 0; i < 6; i++) send(data_t'($urandom), 0);
        wait_done(20);
        check("wrap_count", log_a.size(), 3);
        check("wrap_a0", log_a.size() > 0 ? log_a[0] : addr_t'(0), 9'h1FF);
        check("wrap_a1", log_a.size() > 1 ? log_a[1] : addr_t'(1), 9'h000);
        check("wrap_a2", log_a.size() > 2 ? log_a[2] : addr_t'(0), 9'h001);

        // flush in HIGH with no beat
        a = $urandom; b = $urandom; c = $urandom;
        clear_log();
        do_start(9'h040, 9'h04F);
        send(a, 0); send(b, 0); send(c, 0);
        do_flush(1'b0, '0);
        wait_done(20);
        check("flush_high_count", log_a.size(), 2);
        check_entry("flush_high0", 0, 9'h040, {b, a});
        check_entry("flush_high1", 1, 9'h041, {data_t'(0), c});

        // flush in LOW with no beat
        clear_log();
        do_start(9'h050, 9'h05F);
        send(a, 0); send(b, 0);
        do_flush(1'b0, '0);
        wait_done(20);
        check("flush_low_count", log_a.size(), 1);

        // flush coincident with a beat in LOW
        clear_log();
        do_start(9'h060, 9'h06F);
        send(a, 0); send(b, 0);
        do_flush(1'b1, c);
        wait_done(20);
        check("flush_beat_count", log_a.size(), 2);
        check_entry("flush_beat1", 1, 9'h061, {data_t'(0), c});

        // backpressure, start pulsed mid-run
        clear_log();
        do_start(9'h010, 9'h012);
        for (int i = 1; i <= 6; i++) begin
            send(data_t'(i), 1);
            if (i == 3) do_start(9'h100, 9'h100);
        end
        wait_done(20);
        check("bp_count", log_a.size(), 3);
        check_entry("bp0", 0, 9'h010, 64'h0000000200000001);
        check_entry("bp1", 1, 9'h011, 64'h0000000400000003);
        check_entry("bp2", 2, 9'h012, 64'h0000000600000005);

        // reset while in HIGH
        clear_log();
        do_start(9'h030, 9'h031);
        send(32'hAAAA5555, 0);
        #2 rst_n = 1'b0;
        #1;
        check("midrun_reset_outputs",
              {bus.result_ready_o, bus.sram_write_o, busy_o, done_o, bus.sram_addr_o, bus.sram_wdata_o},
              '0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("midrun_reset_no_write", log_a.size(), 0);
        do_start(9'h005, 9'h005);
        send(a, 0); send(b, 0);
        wait_done(20);
        check("post_reset_count", log_a.size(), 1);
        check_entry("post_reset", 0, 9'h005, {b, a});

        // randomised runs, some ended by flush
        for (int r = 0; r < 12; r++) begin
            w = $urandom_range(1, 4);
            s = addr_t'($urandom);
            use_flush = $urandom_range(0, 1);
            k = use_flush ? $urandom_range(1, 2 * w - 1) : 2 * w;
            clear_log();
            do_start(s, addr_t'(s + w - 1));
            for (int i = 0; i < k; i++) send(data_t'($urandom), $urandom_range(0, 2));
            if (use_flush) do_flush(1'b0, '0);
            wait_done(40);
            check("rand_count", log_a.size(), use_flush ? (k + 1) / 2 : w);
        end

        // full span: 512 words
        clear_log();
        do_start(9'h007, 9'h006);
        for (int i = 0; i < 1024; i++) send(data_t'($urandom), 0);
        wait_done(20);
        check("span_count", log_a.size(), 512);
        check("span_first", log_a.size() > 0 ? log_a[0] : addr_t'(0), 9'h007);
        check("span_last", log_a.size() == 512 ? log_a[511] : addr_t'(0), 9'h006);

        repeat (3) @(negedge clk);
        check("sb_leftover", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/result_writer.md
Name: result_writer

Overview:
- Write-side counterpart to the calculator's SRAM operand read path.
- Accepts a stream of DATA_W-bit results over a valid/ready handshake and packs each pair into one MEM_WORD_SIZE-bit word (first result in the low half).
- Writes each packed word to SRAM at consecutive addresses from a programmed start address to a programmed end address, then pulses done.
- Sits between the calculator datapath and the SRAM write port.

Parameters:
DATA_W, 32, result width (calculator_pkg)
MEM_WORD_SIZE, 64, SRAM word width; must equal 2*DATA_W (calculator_pkg)
ADDR_W, 9, SRAM address width, 512 lines (calculator_pkg)

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
start_i  input  1  one-cycle pulse; latches address range; honoured only in IDLE
write_start_addr_i  input  ADDR_W  first SRAM line to write
write_end_addr_i  input  ADDR_W  last SRAM line to write
result_valid_i  input  1  result_data_i valid
result_ready_o  output  1  block can accept a result
result_data_i  input  DATA_W  calculator result
flush_i  input  1  end of stream; pad the partial word with zero and finish
sram_write_o  output  1  SRAM write enable, one cycle per word
sram_addr_o  output  ADDR_W  SRAM write address
sram_wdata_o  output  MEM_WORD_SIZE  packed word {upper, lower}
busy_o  output  1  high in every state except IDLE
done_o  output  1  one-cycle pulse at end of run

Behaviour:
- Reset: all outputs 0, state IDLE, address and data registers 0. Reset asserted mid-run aborts immediately; no partial SRAM write is issued.
- All outputs are registered or decoded from state. No combinational path from result_valid_i to result_ready_o.
- States:
  - IDLE:
    - start_i → LOW; cur_addr ← write_start_addr_i; end_addr ← write_end_addr_i.
    - Otherwise stay. flush_i and result_valid_i are ignored.
  - LOW:
    - ready=1.
    - Handshake (valid & ready) with no flush → lo ← data; go HIGH.
    - Handshake with flush → lo ← data, hi ← 0, last ← 1; go WRITE.
    - flush without handshake → go DONE; no write.
  - HIGH:
    - ready=1.
    - Handshake → hi ← data; go WRITE; last ← flush_i.
    - flush without handshake → hi ← 0, last ← 1; go WRITE.
  - WRITE:
    - ready=0; sram_write_o=1 for exactly this cycle; sram_addr_o=cur_addr; sram_wdata_o={hi,lo}.
    - Next state: DONE if last or cur_addr==end_addr; else cur_addr ← cur_addr+1 and go LOW.
  - DONE: done_o=1 for one cycle; last cleared; go IDLE.
- start_i outside IDLE is ignored. flush_i in WRITE/DONE is ignored.
- Latency: write cycle immediately follows the cycle accepting the upper half. Peak throughput is 2 results per 3 cycles.
- Address arithmetic is modulo 2^ADDR_W:
  - end < start wraps 511→0 and continues to end.
  - start==end writes exactly one word.
  - Full span (end = start−1 mod 512) writes 512 words.
- Data and address are not modified outside WRITE. sram_addr_o and sram_wdata_o hold their last values when sram_write_o=0.

Decomposition:
- calculator_pkg additions:
  - typedef enum logic [2:0] {IDLE, LOW, HIGH, WRITE, DONE} writer_state_t
  - typedef logic [ADDR_W-1:0] addr_t
  - typedef logic [MEM_WORD_SIZE-1:0] mem_word_t
  - typedef logic [DATA_W-1:0] data_t
- No natural sub-module. FSM, address counter and packing registers stay in result_writer.

Test Plan:
- Basic pair: start 0x000..0x000; results 0x11111111, 0x22222222 → one write at 0x000, data 0x2222222211111111; done 1 cycle later.
- Multi-word: start 0x010..0x012; 6 back-to-back results 1..6 → writes 0x010=0x0000000200000001, 0x011=…0004…0003, 0x012=…0006…0005; done after the third write; ready low during each write cycle.
- Wrap: start 0x1FF..0x001; 6 results → writes at 0x1FF, 0x000, 0x001 in that order.
- Flush:
  - 3 results A,B,C then flush with no beat in HIGH → second word {0, C}, then done.
  - Flush in LOW with no beat → done, no write.
  - Flush coincident with accepting C in LOW → {0, C}, then done.
- Backpressure/ignore: valid toggling every other cycle gives the same SRAM contents as the multi-word case; start_i pulsed mid-run is ignored; busy_o high from start through done.
- Reset mid-run: rst_n low while in HIGH → all outputs 0 immediately, no write. After release, a new start 0x005..0x005 with 2 results writes only 0x005.
